otter_dmem_arbiter: RTL and testbench
=====================================

Name: otter_dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the OTTER memory data port (port 2), with 1-cycle synchronous read and MMIO.
Shares the port between requester 0 (CPU load/store) and requester 1 (DMA/program loader).
Holds address, size and sign stable across the registered-read cycle so the memory's sized/sign-extended MEM_DOUT2 is correct.
Returns registered read data with a one-cycle ACK.

Parameters:
PERF_W, 32, width of optional performance counters

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
R0_REQ  in  1  requester 0 access request; held with fields until R0_GNT
R0_WE  in  1  requester 0: 1 = store, 0 = load
R0_ADDR  in  32  requester 0 byte address
R0_DIN  in  32  requester 0 store data
R0_SIZE  in  2  requester 0 size: 0 byte, 1 half, 2 word
R0_SIGN  in  1  requester 0: 1 unsigned, 0 signed
R0_GNT  out  1  request 0 accepted (one-cycle pulse)
R0_ACK  out  1  request 0 complete (one-cycle pulse)
R0_RDATA  out  32  request 0 load data, valid with R0_ACK
R1_*  same set as R0_* for requester 1
MEM_RDEN2  out  1  to memory data read enable
MEM_WE2  out  1  to memory write enable
MEM_ADDR2  out  32  to memory data address
MEM_DIN2  out  32  to memory store data
MEM_SIZE  out  2  to memory size
MEM_SIGN  out  1  to memory sign
MEM_DOUT2  in  32  from memory sized data (includes IO buffer for addr >= 0x10000)

Behaviour:
- States: IDLE, ISSUE, DATA, RESP. Reset -> IDLE.
- Reset values: all outputs 0; hold registers 0; last_grant = 1, so requester 0 wins the first tie. Reset mid-operation aborts without any further MEM_WE2/MEM_RDEN2.
- Arbitration happens in IDLE and RESP:
  - Single requester: it wins.
  - Both requesting: the one not equal to last_grant wins (round-robin).
  - At the clock edge: latch winner's WE/ADDR/DIN/SIZE/SIGN into hold regs, update last_grant, go to ISSUE.
  - No requester: IDLE -> IDLE, RESP -> IDLE.
- ISSUE:
  - GNT of winner = 1 for this cycle only.
  - MEM_* driven from hold regs; MEM_WE2 = hold_we; MEM_RDEN2 = ~hold_we.
  - Write -> RESP. Read -> DATA.
- DATA (reads only):
  - MEM_ADDR2/SIZE/SIGN still driven from hold regs; MEM_RDEN2 = 0; MEM_WE2 = 0.
  - At the edge, MEM_DOUT2 is captured into winner's RDATA; -> RESP.
- RESP:
  - ACK of winner = 1 for one cycle. RDATA valid for loads, unchanged for stores.
  - RDATA holds until that requester's next load completes.
  - Arbitrates as IDLE, so back-to-back throughput is 3 cycles per load and 2 per store.
- MEM_* outputs are registered from state/hold regs; no combinational path from R*_REQ to MEM_*.
- MEM_WE2 and MEM_RDEN2 are never high together, and are never high outside ISSUE.
- Requester rules:
  - REQ and fields stay stable from assertion until the GNT cycle.
  - Requester may drop REQ or present a new request after GNT.
  - REQ deasserted before grant is legal: the request is withdrawn and no access occurs.
- Size/offset legality is not checked: illegal combinations pass through unchanged (memory ignores store / returns 0).
- MMIO address >= 0x10000 is handled identically; IO_WR is generated by memory from MEM_WE2.
- GNT and ACK are never high for both requesters in the same cycle.

Optional Feature:
Macro OTTER_DMEM_ARB_PERF_EN.
- Defined: adds outputs PERF_GNT0, PERF_GNT1 and PERF_CONFLICT, each PERF_W wide, reset 0.
  - PERF_GNT0/PERF_GNT1 increment on each GNT pulse for that requester.
  - PERF_CONFLICT increments in every cycle where both REQs are high in IDLE/RESP.
  - Counters wrap modulo 2^PERF_W.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Preload word 0x80 = 0xDEADBEEF; R0 load, ADDR 0x82, SIZE 0, SIGN 0 -> R0_GNT at cycle 1, MEM_ADDR2 = 0x82 held through cycles 1-2, R0_ACK at cycle 3, R0_RDATA = 0xFFFFFFAD.
2. R1 store word 0x12345678 to 0x100, then R1 load word 0x100 -> store ACK 2 cycles after request, load R1_RDATA = 0x12345678, MEM_WE2 high exactly one cycle.
3. R0 and R1 both request continuously (reads to 0x0 and 0x4) -> grants alternate R0, R1, R0, R1; no GNT/ACK overlap; R0 first after reset.
4. R0 load of MMIO 0x11000000 with memory IO_IN = 0x0000A5A5 -> R0_RDATA = 0x0000A5A5; MEM_WE2 never asserted.
5. Assert RST_N low during DATA of a read -> all outputs 0 immediately, state IDLE, no ACK; a fresh R1 request after release is granted normally.
6. With OTTER_DMEM_ARB_PERF_EN, run scenario 3 for 10 grants -> PERF_GNT0 = 5, PERF_GNT1 = 5, PERF_CONFLICT = number of arbitration cycles with both REQs high.

Source files
------------

// File: rtl/otter_dmem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the OTTER data port.
// Define OTTER_DMEM_ARB_PERF_EN to add grant/conflict performance counters.
module otter_dmem_arbiter #(
    parameter int PERF_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              R0_REQ,
    input  logic              R0_WE,
    input  logic [31:0]       R0_ADDR,
    input  logic [31:0]       R0_DIN,
    input  logic [1:0]        R0_SIZE,
    input  logic              R0_SIGN,
    output logic              R0_GNT,
    output logic              R0_ACK,
    output logic [31:0]       R0_RDATA,
    input  logic              R1_REQ,
    input  logic              R1_WE,
    input  logic [31:0]       R1_ADDR,
    input  logic [31:0]       R1_DIN,
    input  logic [1:0]        R1_SIZE,
    input  logic              R1_SIGN,
    output logic              R1_GNT,
    output logic              R1_ACK,
    output logic [31:0]       R1_RDATA,
`ifdef OTTER_DMEM_ARB_PERF_EN
    output logic [PERF_W-1:0] PERF_GNT0,
    output logic [PERF_W-1:0] PERF_GNT1,
    output logic [PERF_W-1:0] PERF_CONFLICT,
`endif
    output logic              MEM_RDEN2,
    output logic              MEM_WE2,
    output logic [31:0]       MEM_ADDR2,
    output logic [31:0]       MEM_DIN2,
    output logic [1:0]        MEM_SIZE,
    output logic              MEM_SIGN,
    input  logic [31:0]       MEM_DOUT2
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        hold_id_q, hold_id_d;
    logic        last_q, last_d;
    logic        hold_we_q, hold_we_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] hold_din_q, hold_din_d;
    logic [1:0]  hold_size_q, hold_size_d;
    logic        hold_sign_q, hold_sign_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic arb, both, any_req, win_id, issue, resp;

    assign arb     = (state_q == S_IDLE) || (state_q == S_RESP);
    assign both    = R0_REQ & R1_REQ;
    assign any_req = R0_REQ | R1_REQ;
    // On a tie the requester that did not win last time goes next.
    assign win_id  = both ? ~last_q : R1_REQ;

    always_comb begin
        state_d     = state_q;
        hold_id_d   = hold_id_q;
        last_d      = last_q;
        hold_we_d   = hold_we_q;
        hold_addr_d = hold_addr_q;
        hold_din_d  = hold_din_q;
        hold_size_d = hold_size_q;
        hold_sign_d = hold_sign_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        unique case (state_q)
            S_IDLE, S_RESP: begin
                if (any_req) begin
                    state_d     = S_ISSUE;
                    hold_id_d   = win_id;
                    last_d      = win_id;
                    hold_we_d   = win_id ? R1_WE   : R0_WE;
                    hold_addr_d = win_id ? R1_ADDR : R0_ADDR;
                    hold_din_d  = win_id ? R1_DIN  : R0_DIN;
                    hold_size_d = win_id ? R1_SIZE : R0_SIZE;
                    hold_sign_d = win_id ? R1_SIGN : R0_SIGN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = hold_we_q ? S_RESP : S_DATA;
            S_DATA: begin
                state_d = S_RESP;
                if (hold_id_q) rdata1_d = MEM_DOUT2;
                else           rdata0_d = MEM_DOUT2;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            hold_id_q   <= 1'b0;
            last_q      <= 1'b1;
            hold_we_q   <= 1'b0;
            hold_addr_q <= '0;
            hold_din_q  <= '0;
            hold_size_q <= '0;
            hold_sign_q <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            hold_id_q   <= hold_id_d;
            last_q      <= last_d;
            hold_we_q   <= hold_we_d;
            hold_addr_q <= hold_addr_d;
            hold_din_q  <= hold_din_d;
            hold_size_q <= hold_size_d;
            hold_sign_q <= hold_sign_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign issue = (state_q == S_ISSUE);
    assign resp  = (state_q == S_RESP);

    assign R0_GNT   = issue & ~hold_id_q;
    assign R1_GNT   = issue &  hold_id_q;
    assign R0_ACK   = resp  & ~hold_id_q;
    assign R1_ACK   = resp  &  hold_id_q;
    assign R0_RDATA = rdata0_q;
    assign R1_RDATA = rdata1_q;

    // Address/size/sign stay on the port through DATA for the memory's sizing.
    assign MEM_WE2   = issue &  hold_we_q;
    assign MEM_RDEN2 = issue & ~hold_we_q;
    assign MEM_ADDR2 = hold_addr_q;
    assign MEM_DIN2  = hold_din_q;
    assign MEM_SIZE  = hold_size_q;
    assign MEM_SIGN  = hold_sign_q;

`ifdef OTTER_DMEM_ARB_PERF_EN
    logic [PERF_W-1:0] gnt0_q, gnt1_q, conf_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gnt0_q <= '0;
            gnt1_q <= '0;
            conf_q <= '0;
        end else begin
            if (R0_GNT)      gnt0_q <= gnt0_q + 1'b1;
            if (R1_GNT)      gnt1_q <= gnt1_q + 1'b1;
            if (arb && both) conf_q <= conf_q + 1'b1;
        end
    end

    assign PERF_GNT0     = gnt0_q;
    assign PERF_GNT1     = gnt1_q;
    assign PERF_CONFLICT = conf_q;
`endif

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Self-checking bench for otter_dmem_arbiter: transaction-level model,
// synchronous-read memory with MMIO word, directed scenarios.
module tb_otter_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        R0_REQ, R0_WE, R0_SIGN, R0_GNT, R0_ACK;
    logic [31:0] R0_ADDR, R0_DIN, R0_RDATA;
    logic [1:0]  R0_SIZE;
    logic        R1_REQ, R1_WE, R1_SIGN, R1_GNT, R1_ACK;
    logic [31:0] R1_ADDR, R1_DIN, R1_RDATA;
    logic [1:0]  R1_SIZE;
    logic        MEM_RDEN2, MEM_WE2, MEM_SIGN;
    logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
    logic [1:0]  MEM_SIZE;
`ifdef OTTER_DMEM_ARB_PERF_EN
    logic [31:0] PERF_GNT0, PERF_GNT1, PERF_CONFLICT;
`endif

    otter_dmem_arbiter #(.PERF_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .R0_REQ(R0_REQ), .R0_WE(R0_WE), .R0_ADDR(R0_ADDR), .R0_DIN(R0_DIN),
        .R0_SIZE(R0_SIZE), .R0_SIGN(R0_SIGN), .R0_GNT(R0_GNT),
        .R0_ACK(R0_ACK), .R0_RDATA(R0_RDATA),
        .R1_REQ(R1_REQ), .R1_WE(R1_WE), .R1_ADDR(R1_ADDR), .R1_DIN(R1_DIN),
        .R1_SIZE(R1_SIZE), .R1_SIGN(R1_SIGN), .R1_GNT(R1_GNT),
        .R1_ACK(R1_ACK), .R1_RDATA(R1_RDATA),
`ifdef OTTER_DMEM_ARB_PERF_EN
        .PERF_GNT0(PERF_GNT0), .PERF_GNT1(PERF_GNT1),
        .PERF_CONFLICT(PERF_CONFLICT),
`endif
        .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2),
        .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_DOUT2(MEM_DOUT2)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] ext(input logic [31:0] w,
        input logic [1:0] off, input logic [1:0] sz, input logic uns);
        logic [31:0] s;
        s = w >> (8 * off);
        case (sz)
            2'd0: return uns ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            2'd1: return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            2'd2: return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
        input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz);
        logic [31:0] r;
        r = old;
        case (sz)
            2'd0: r[8*off +: 8] = d[7:0];
            2'd1: if (off[0] == 1'b0) r[8*off +: 16] = d[15:0];
            2'd2: if (off == 2'd0) r = d;
            default: r = old;
        endcase
        return r;
    endfunction

    // ---------------- memory environment ----------------
    logic [31:0] mem [0:1023];
    logic [31:0] io_in;
    logic [31:0] rd_word;

    always @(posedge CLK) begin
        if (MEM_RDEN2)
            rd_word <= (MEM_ADDR2 >= 32'h10000) ? io_in : mem[MEM_ADDR2[11:2]];
        if (MEM_WE2 && MEM_ADDR2 < 32'h10000)
            mem[MEM_ADDR2[11:2]] <= merge(mem[MEM_ADDR2[11:2]], MEM_DIN2,
                                          MEM_ADDR2[1:0], MEM_SIZE);
    end

    assign MEM_DOUT2 = ext(rd_word, MEM_ADDR2[1:0], MEM_SIZE, MEM_SIGN);

    // ---------------- transaction-level model ----------------
    logic [31:0] ref_mem [0:1023];
    bit          m_busy;
    int          m_off, m_len, m_who, m_last;
    bit          m_we, m_sign;
    logic [31:0] m_addr, m_din;
    logic [1:0]  m_size;
    logic [31:0] m_rd [2];
    int          m_g [2];
    int          m_cf;
    bit          m_free;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_busy = 0; m_last = 1; m_off = 0; m_len = 0; m_who = 0;
            m_we = 0; m_addr = 0; m_din = 0; m_size = 0; m_sign = 0;
            m_rd[0] = 0; m_rd[1] = 0; m_g[0] = 0; m_g[1] = 0; m_cf = 0;
        end else begin
            if (m_busy && m_we && m_off == 0 && m_addr < 32'h10000)
                ref_mem[m_addr[11:2]] = merge(ref_mem[m_addr[11:2]], m_din,
                                              m_addr[1:0], m_size);
            if (m_busy && !m_we && m_off == 1)
                m_rd[m_who] = ext((m_addr >= 32'h10000) ? io_in
                                  : ref_mem[m_addr[11:2]],
                                  m_addr[1:0], m_size, m_sign);
            m_free = !m_busy || (m_off == m_len - 1);
            if (m_free) begin
                if (R0_REQ && R1_REQ) m_cf++;
                if (R0_REQ || R1_REQ) begin
                    if (R0_REQ && R1_REQ) m_who = 1 - m_last;
                    else                  m_who = R1_REQ ? 1 : 0;
                    m_last = m_who;
                    m_g[m_who]++;
                    m_we   = (m_who == 1) ? R1_WE   : R0_WE;
                    m_addr = (m_who == 1) ? R1_ADDR : R0_ADDR;
                    m_din  = (m_who == 1) ? R1_DIN  : R0_DIN;
                    m_size = (m_who == 1) ? R1_SIZE : R0_SIZE;
                    m_sign = (m_who == 1) ? R1_SIGN : R0_SIGN;
                    m_busy = 1; m_off = 0;
                    m_len  = m_we ? 2 : 3;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_off++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 0;

    always @(negedge CLK) begin
        if (chk_en) begin
            logic g, a;
            g = m_busy && m_off == 0;
            a = m_busy && m_off == m_len - 1;
            chk("R0_GNT", R0_GNT, 32'(g && m_who == 0));
            chk("R1_GNT", R1_GNT, 32'(g && m_who == 1));
            chk("R0_ACK", R0_ACK, 32'(a && m_who == 0));
            chk("R1_ACK", R1_ACK, 32'(a && m_who == 1));
            chk("MEM_WE2", MEM_WE2, 32'(g && m_we));
            chk("MEM_RDEN2", MEM_RDEN2, 32'(g && !m_we));
            chk("R0_RDATA", R0_RDATA, m_rd[0]);
            chk("R1_RDATA", R1_RDATA, m_rd[1]);
            if (m_busy) begin
                chk("MEM_ADDR2", MEM_ADDR2, m_addr);
                chk("MEM_SIZE", 32'(MEM_SIZE), 32'(m_size));
                chk("MEM_SIGN", 32'(MEM_SIGN), 32'(m_sign));
            end
            if (g && m_we) chk("MEM_DIN2", MEM_DIN2, m_din);
`ifdef OTTER_DMEM_ARB_PERF_EN
            chk("PERF_GNT0", PERF_GNT0, 32'(m_g[0]));
            chk("PERF_GNT1", PERF_GNT1, 32'(m_g[1]));
            chk("PERF_CONFLICT", PERF_CONFLICT, 32'(m_cf));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_req(input int id, input logic we, input logic [31:0] ad,
        input logic [31:0] d, input logic [1:0] sz, input logic sg);
        if (id == 0) begin
            R0_WE = we; R0_ADDR = ad; R0_DIN = d; R0_SIZE = sz; R0_SIGN = sg;
            R0_REQ = 1'b1;
        end else begin
            R1_WE = we; R1_ADDR = ad; R1_DIN = d; R1_SIZE = sz; R1_SIGN = sg;
            R1_REQ = 1'b1;
        end
    endtask

    // Runs one request from a negedge; reports grant/ack cycle offsets.
    task automatic run_one(input int id, input logic we, input logic [31:0] ad,
        input logic [31:0] d, input logic [1:0] sz, input logic sg,
        output int tg, output int ta, output int nwe, output int nrd,
        output logic [31:0] a1, output logic [31:0] a2);
        logic gn, ak;
        tg = -1; ta = -1; nwe = 0; nrd = 0; a1 = 0; a2 = 0;
        @(negedge CLK);
        set_req(id, we, ad, d, sz, sg);
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            gn = (id == 0) ? R0_GNT : R1_GNT;
            ak = (id == 0) ? R0_ACK : R1_ACK;
            if (gn && tg < 0) begin
                tg = k;
                if (id == 0) R0_REQ = 1'b0; else R1_REQ = 1'b0;
            end
            if (ak && ta < 0) ta = k;
            if (MEM_WE2) nwe++;
            if (MEM_RDEN2) nrd++;
            if (k == 1) a1 = MEM_ADDR2;
            if (k == 2) a2 = MEM_ADDR2;
        end
        R0_REQ = 1'b0; R1_REQ = 1'b0;
    endtask

    int tg, ta, nwe, nrd, ng, guard, acks;
    logic [31:0] a1, a2;
    int seq [10];

    initial begin
        RST_N = 1'b0;
        R0_REQ = 0; R0_WE = 0; R0_ADDR = 0; R0_DIN = 0; R0_SIZE = 0; R0_SIGN = 0;
        R1_REQ = 0; R1_WE = 0; R1_ADDR = 0; R1_DIN = 0; R1_SIZE = 0; R1_SIGN = 0;
        rd_word = 0;
        io_in = 32'h0000A5A5;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h0100_0000 + 32'(i);
            ref_mem[i] = 32'h0100_0000 + 32'(i);
        end
        mem[32'h80 >> 2] = 32'hDEADBEEF;
        ref_mem[32'h80 >> 2] = 32'hDEADBEEF;
        repeat (2) @(negedge CLK);
        chk("rst_gnt", {R0_GNT, R1_GNT, R0_ACK, R1_ACK}, 32'h0);
        chk("rst_en", {MEM_WE2, MEM_RDEN2}, 32'h0);
        chk("rst_addr", MEM_ADDR2, 32'h0);
        chk("rst_din", MEM_DIN2, 32'h0);
        chk("rst_rdata0", R0_RDATA, 32'h0);
        RST_N = 1'b1;
        chk_en = 1;

        // Both requesters continuously: strict alternation, R0 first.
        @(negedge CLK);
        set_req(0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        set_req(1, 1'b0, 32'h4, 32'h0, 2'd2, 1'b0);
        ng = 0; guard = 0;
        while (ng < 10 && guard < 100) begin
            @(negedge CLK);
            guard++;
            if (R0_GNT && ng < 10) begin seq[ng] = 0; ng++; end
            if (R1_GNT && ng < 10) begin seq[ng] = 1; ng++; end
        end
        R0_REQ = 1'b0; R1_REQ = 1'b0;
        chk("rr_grants", 32'(ng), 32'd10);
        for (int i = 0; i < 10; i++) chk("rr_order", 32'(seq[i]), 32'(i % 2));
        repeat (4) @(negedge CLK);
        chk("rr_rdata0", R0_RDATA, 32'h0100_0000);
        chk("rr_rdata1", R1_RDATA, 32'h0100_0001);
`ifdef OTTER_DMEM_ARB_PERF_EN
        chk("perf_gnt0", PERF_GNT0, 32'd5);
        chk("perf_gnt1", PERF_GNT1, 32'd5);
        chk("perf_conflict", PERF_CONFLICT, 32'd10);
`endif

        // Signed byte load from inside a preloaded word.
        run_one(0, 1'b0, 32'h82, 32'h0, 2'd0, 1'b0, tg, ta, nwe, nrd, a1, a2);
        chk("ld_gnt_cyc", 32'(tg), 32'd1);
        chk("ld_ack_cyc", 32'(ta), 32'd3);
        chk("ld_addr_c1", a1, 32'h82);
        chk("ld_addr_c2", a2, 32'h82);
        chk("ld_rden", 32'(nrd), 32'd1);
        chk("ld_rdata", R0_RDATA, 32'hFFFFFFAD);

        // R1 store then load back.
        run_one(1, 1'b1, 32'h100, 32'h12345678, 2'd2, 1'b0,
                tg, ta, nwe, nrd, a1, a2);
        chk("st_ack_cyc", 32'(ta), 32'd2);
        chk("st_we_cnt", 32'(nwe), 32'd1);
        chk("st_rdata_kept", R1_RDATA, 32'h0100_0001);
        run_one(1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, tg, ta, nwe, nrd, a1, a2);
        chk("ldb_ack_cyc", 32'(ta), 32'd3);
        chk("ldb_we_cnt", 32'(nwe), 32'd0);
        chk("ldb_rdata", R1_RDATA, 32'h12345678);

        // Unsigned halfword, upper lane.
        run_one(0, 1'b0, 32'h82, 32'h0, 2'd1, 1'b1, tg, ta, nwe, nrd, a1, a2);
        chk("ldh_rdata", R0_RDATA, 32'h0000DEAD);

        // MMIO load.
        run_one(0, 1'b0, 32'h11000000, 32'h0, 2'd2, 1'b0,
                tg, ta, nwe, nrd, a1, a2);
        chk("io_rdata", R0_RDATA, 32'h0000A5A5);
        chk("io_we_cnt", 32'(nwe), 32'd0);

        // Reset during DATA of a read.
        @(negedge CLK);
        set_req(0, 1'b0, 32'h80, 32'h0, 2'd2, 1'b0);
        @(negedge CLK);
        chk("rr_gnt_pre", 32'(R0_GNT), 32'd1);
        R0_REQ = 1'b0;
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_en", {MEM_WE2, MEM_RDEN2}, 32'h0);
        chk("arst_hs", {R0_GNT, R1_GNT, R0_ACK, R1_ACK}, 32'h0);
        chk("arst_addr", MEM_ADDR2, 32'h0);
        chk("arst_rdata0", R0_RDATA, 32'h0);
        chk("arst_rdata1", R1_RDATA, 32'h0);
        acks = 0;
        repeat (2) begin
            @(negedge CLK);
            if (R0_ACK || R1_ACK || MEM_WE2 || MEM_RDEN2) acks++;
        end
        chk("arst_quiet", 32'(acks), 32'd0);
        RST_N = 1'b1;
        run_one(1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, tg, ta, nwe, nrd, a1, a2);
        chk("post_gnt_cyc", 32'(tg), 32'd1);
        chk("post_ack_cyc", 32'(ta), 32'd3);
        chk("post_rdata", R1_RDATA, 32'h12345678);

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
